// File: rtl/rk8e_break_requester.sv
// rk8e_break_requester
//   Device-side end of the CPU data-break channel for the RK8E disk controller.
//   A start pulse latches a block-transfer command (direction, 15-bit address,
//   word count). Each word is moved in one CPU break cycle (DB0/DB1/DB2).
//   Disk-side words arrive and leave through valid/ready handshakes.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start                 1-cycle command strobe (ignored while busy)
//   cmd_to_disk           1 = memory->disk (memory read), 0 = disk->memory (write)
//   cmd_addr              start address: field [14:12], word [11:0]
//   cmd_count             words to move, 0 means 4096
//   abort                 stop at the next break boundary
//   cpu_state             CPU major-state register
//   break_in_prog         CPU break-in-progress flag
//   mem_rdata             memory read data, valid in DB1
//   din_valid/din_data    disk->memory word stream; din_ready accepts it
//   dout_valid/dout_data  memory->disk word stream; dout_ready accepts it
//   data_break            break request to the CPU
//   to_disk               direction of the current transfer
//   db_addr               memory address during a break (0 otherwise)
//   mem_wdata, mem_we     write data and single-cycle DB1 write strobe
//   busy, done            transfer active / 1-cycle completion pulse
//   cur_addr              next address to be used (current-address register)
//
// PDP-8 bit numbering maps as: address bit 0 -> [14], bit 14 -> [0].
module rk8e_break_requester #(
  parameter logic [4:0] DB0_ST = 5'd24,
  parameter logic [4:0] DB1_ST = 5'd25,
  parameter logic [4:0] DB2_ST = 5'd26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_to_disk,
  input  logic [14:0] cmd_addr,
  input  logic [11:0] cmd_count,
  input  logic        abort,
  input  logic [4:0]  cpu_state,
  input  logic        break_in_prog,
  input  logic [11:0] mem_rdata,
  input  logic        din_valid,
  input  logic [11:0] din_data,
  output logic        din_ready,
  output logic        dout_valid,
  output logic [11:0] dout_data,
  input  logic        dout_ready,
  output logic        data_break,
  output logic        to_disk,
  output logic [14:0] db_addr,
  output logic [11:0] mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic [14:0] cur_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_REQ,
    S_BRK,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e      state_q;
  logic        to_disk_q;
  logic [14:0] cur_addr_q;
  logic [12:0] remaining_q;   // 13 bits so a zero count can hold 4096
  logic        abort_q;
  logic [11:0] wdata_q;
  logic [11:0] rdata_q;

  logic abort_seen;
  logic db0_hit;

  // An abort pulse counts from the cycle it arrives, even before it is latched.
  assign abort_seen = abort_q | abort;
  // The CPU has entered the break cycle for us.
  assign db0_hit    = break_in_prog && (cpu_state == DB0_ST);

  // NOTE: every register, including the data holding registers, is cleared by
  // the synchronous reset so a reset leaves no stale word on the buses.
  // NOTE: all state uses non-blocking assignments so every branch below sees
  // the pre-edge values of the other registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      to_disk_q   <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      abort_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A start coincident with abort starts cleanly; the abort is dropped.
          if (start) begin
            to_disk_q   <= cmd_to_disk;
            cur_addr_q  <= cmd_addr;
            remaining_q <= (cmd_count == 12'd0) ? 13'd4096 : {1'b0, cmd_count};
            abort_q     <= 1'b0;
            state_q     <= cmd_to_disk ? S_REQ : S_FILL;
          end
        end
        S_FILL: begin
          abort_q <= abort_seen;
          if (abort_seen) begin
            state_q <= S_FIN;
          end else if (din_valid) begin
            wdata_q <= din_data;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          abort_q <= abort_seen;
          // Once DB0 is seen the break is committed and completes despite abort.
          if (db0_hit) begin
            state_q <= S_BRK;
          end else if (abort_seen) begin
            state_q <= S_FIN;
          end
        end
        S_BRK: begin
          abort_q <= abort_seen;
          if (to_disk_q && (cpu_state == DB1_ST)) begin
            rdata_q <= mem_rdata;
          end
          if (cpu_state == DB2_ST) begin
            // Only the word field advances; the field bits never change.
            cur_addr_q  <= {cur_addr_q[14:12], cur_addr_q[11:0] + 12'd1};
            remaining_q <= remaining_q - 13'd1;
            if (to_disk_q) begin
              state_q <= S_DRAIN;
            end else if ((remaining_q == 13'd1) || abort_seen) begin
              state_q <= S_FIN;
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_DRAIN: begin
          abort_q <= abort_seen;
          if (dout_ready) begin
            state_q <= ((remaining_q == 13'd0) || abort_seen) ? S_FIN : S_REQ;
          end
        end
        S_FIN: begin
          abort_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Status and handshake outputs are decodes of the state register. The break
  // request and write strobe also follow cpu_state/abort within the same
  // cycle: the request must fall as soon as DB0 (or an abort) is seen, and the
  // write strobe must cover exactly the DB1 cycle.
  assign busy       = (state_q == S_FILL) || (state_q == S_REQ) ||
                      (state_q == S_BRK)  || (state_q == S_DRAIN);
  assign done       = (state_q == S_FIN);
  assign din_ready  = (state_q == S_FILL) && !abort_seen;
  assign dout_valid = (state_q == S_DRAIN);
  assign dout_data  = rdata_q;
  assign data_break = (state_q == S_REQ) && !db0_hit && !abort_seen;
  assign to_disk    = to_disk_q;
  assign db_addr    = (state_q == S_BRK) ? cur_addr_q : 15'd0;
  assign mem_wdata  = wdata_q;
  assign mem_we     = (state_q == S_BRK) && !to_disk_q && (cpu_state == DB1_ST);
  assign cur_addr   = cur_addr_q;

endmodule

// File: tb/tb_rk8e_break_requester.sv
// Testbench for rk8e_break_requester: single-word transfers from a vector
// table, then hand-written multi-word, drain-stall, wrap, 4096-word, abort and
// reset sequences. The bench plays the CPU (F3 -> DB0 -> DB1 -> DB2) and both
// disk-side handshake partners.
module tb_rk8e_break_requester;

  localparam logic [4:0] DB0 = 5'd24;
  localparam logic [4:0] DB1 = 5'd25;
  localparam logic [4:0] DB2 = 5'd26;
  localparam logic [4:0] F3  = 5'd3;
  localparam int         REQ_BUDGET = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cmd_to_disk;
  logic [14:0] cmd_addr;
  logic [11:0] cmd_count;
  logic        abort;
  logic [4:0]  cpu_state;
  logic        break_in_prog;
  logic [11:0] mem_rdata;
  logic        din_valid;
  logic [11:0] din_data;
  logic        din_ready;
  logic        dout_valid;
  logic [11:0] dout_data;
  logic        dout_ready;
  logic        data_break;
  logic        to_disk;
  logic [14:0] db_addr;
  logic [11:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic [14:0] cur_addr;

  rk8e_break_requester dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cmd_to_disk  (cmd_to_disk),
    .cmd_addr     (cmd_addr),
    .cmd_count    (cmd_count),
    .abort        (abort),
    .cpu_state    (cpu_state),
    .break_in_prog(break_in_prog),
    .mem_rdata    (mem_rdata),
    .din_valid    (din_valid),
    .din_data     (din_data),
    .din_ready    (din_ready),
    .dout_valid   (dout_valid),
    .dout_data    (dout_data),
    .dout_ready   (dout_ready),
    .data_break   (data_break),
    .to_disk      (to_disk),
    .db_addr      (db_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .busy         (busy),
    .done         (done),
    .cur_addr     (cur_addr)
  );

  always #5 clk = ~clk;

  int n_cmp      = 0;
  int n_fail     = 0;
  int timeouts   = 0;
  int we_count   = 0;
  int done_count = 0;

  // Independent pulse counters, sampled on the active edge.
  always @(posedge clk) begin
    if (mem_we) we_count <= we_count + 1;
    if (done)   done_count <= done_count + 1;
  end

  typedef struct {
    logic        dir;       // 1 = memory->disk
    logic [14:0] addr;
    logic [11:0] data;
    logic [14:0] exp_next;
  } vec_t;

  vec_t vecs [6];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'o%0o, expected 'o%0o", name, act, exp);
    end
  endtask

  task automatic start_xfer(input logic dir, input logic [14:0] addr,
                            input logic [11:0] cnt, input logic ab);
    start       = 1'b1;
    cmd_to_disk = dir;
    cmd_addr    = addr;
    cmd_count   = cnt;
    abort       = ab;
    cyc();
    start       = 1'b0;
    abort       = 1'b0;
    cmd_to_disk = 1'b0;
    cmd_addr    = '0;
    cmd_count   = '0;
    #1;
  endtask

  // Offer one disk word; the request must follow one cycle after acceptance.
  task automatic feed_word(input logic [11:0] w);
    for (int i = 0; i < REQ_BUDGET && !din_ready; i++) cyc();
    if (!din_ready) begin
      timeouts++;
      check("din_ready_timeout", 32'd0, 32'd1);
      return;
    end
    din_valid = 1'b1;
    din_data  = w;
    cyc();
    din_valid = 1'b0;
    din_data  = 12'o0;
    #1;
    check("req_latency", data_break, 1'b1);
  endtask

  // Play one CPU break cycle. Returns #1 after the edge that ends DB2.
  task automatic cpu_break(input logic [14:0] exp_addr, input logic wr,
                           input logic [11:0] data, input logic abort_db1);
    for (int i = 0; i < REQ_BUDGET && !data_break; i++) cyc();
    if (!data_break) begin
      timeouts++;
      check("data_break_timeout", 32'd0, 32'd1);
      return;
    end
    cpu_state = F3;
    cyc();
    check("req_hold_f3", data_break, 1'b1);
    cpu_state     = DB0;
    break_in_prog = 1'b1;
    cyc();
    check("req_drop_db0", data_break, 1'b0);
    check("we_db0", mem_we, 1'b0);
    check("addr_db0", db_addr, exp_addr);
    cpu_state = DB1;
    if (!wr) mem_rdata = data;
    if (abort_db1) abort = 1'b1;
    cyc();
    check("addr_db1", db_addr, exp_addr);
    check("we_db1", mem_we, wr);
    if (wr) check("wdata_db1", mem_wdata, data);
    cpu_state = DB2;
    mem_rdata = 12'o5555;
    abort     = 1'b0;
    cyc();
    cpu_state     = 5'd0;
    break_in_prog = 1'b0;
    #1;
  endtask

  initial begin
    int          we0;
    int          d0;
    logic [11:0] w;
    logic [11:0] words [5];

    vecs[0] = '{1'b0, 15'o12345, 12'o1111, 15'o12346};
    vecs[1] = '{1'b1, 15'o00100, 12'o7070, 15'o00101};
    vecs[2] = '{1'b0, 15'o37777, 12'o0001, 15'o30000};
    vecs[3] = '{1'b1, 15'o07777, 12'o7777, 15'o00000};
    vecs[4] = '{1'b0, 15'o00000, 12'o4321, 15'o00001};
    vecs[5] = '{1'b1, 15'o55555, 12'o2525, 15'o55556};

    reset = 1'b1; start = 1'b0; cmd_to_disk = 1'b0; cmd_addr = '0; cmd_count = '0;
    abort = 1'b0; cpu_state = 5'd0; break_in_prog = 1'b0; mem_rdata = '0;
    din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data_break", data_break, 1'b0);
    check("rst_din_ready", din_ready, 1'b0);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout_data", dout_data, 12'o0);
    check("rst_to_disk", to_disk, 1'b0);
    check("rst_db_addr", db_addr, 15'o0);
    check("rst_mem_wdata", mem_wdata, 12'o0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_cur_addr", cur_addr, 15'o0);

    // Single-word transfers in both directions, including field-local wrap.
    for (int i = 0; i < 6; i++) begin
      start_xfer(vecs[i].dir, vecs[i].addr, 12'd1, 1'b0);
      check("vec_busy", busy, 1'b1);
      check("vec_to_disk", to_disk, vecs[i].dir);
      if (!vecs[i].dir) feed_word(vecs[i].data);
      cpu_break(vecs[i].addr, !vecs[i].dir, vecs[i].data, 1'b0);
      if (vecs[i].dir) begin
        check("vec_dout_valid", dout_valid, 1'b1);
        check("vec_dout_data", dout_data, vecs[i].data);
        dout_ready = 1'b1;
        cyc();
        dout_ready = 1'b0;
        #1;
      end
      check("vec_done", done, 1'b1);
      check("vec_busy_fin", busy, 1'b0);
      check("vec_cur_addr", cur_addr, vecs[i].exp_next);
      cyc();
      check("vec_done_clear", done, 1'b0);
    end

    // Three-word write from 0o12345.
    words[0] = 12'o1111; words[1] = 12'o2222; words[2] = 12'o3333;
    we0 = we_count;
    start_xfer(1'b0, 15'o12345, 12'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      feed_word(words[k]);
      cpu_break(15'o12345 + 15'(k), 1'b1, words[k], 1'b0);
      if (k < 2) check("wr3_no_early_done", done, 1'b0);
    end
    check("wr3_done", done, 1'b1);
    check("wr3_cur_addr", cur_addr, 15'o12350);
    check("wr3_we_pulses", we_count - we0, 3);
    cyc();

    // Two-word read with a five-cycle drain stall.
    start_xfer(1'b1, 15'o00100, 12'd2, 1'b0);
    cpu_break(15'o00100, 1'b0, 12'o7070, 1'b0);
    check("rd_dout_valid", dout_valid, 1'b1);
    check("rd_dout_data", dout_data, 12'o7070);
    repeat (5) begin
      cyc();
      check("rd_stall_valid", dout_valid, 1'b1);
      check("rd_stall_data", dout_data, 12'o7070);
      check("rd_stall_no_req", data_break, 1'b0);
    end
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    #1;
    check("rd_drained", dout_valid, 1'b0);
    check("rd_req2", data_break, 1'b1);
    cpu_break(15'o00101, 1'b0, 12'o0707, 1'b0);
    check("rd_dout_data2", dout_data, 12'o0707);
    check("rd_no_done_before_drain", done, 1'b0);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    #1;
    check("rd_done", done, 1'b1);
    check("rd_cur_addr", cur_addr, 15'o00102);
    cyc();

    // Word field wraps 7777 -> 0000 inside field 3.
    start_xfer(1'b0, 15'o37776, 12'd4, 1'b0);
    feed_word(12'o0011); cpu_break(15'o37776, 1'b1, 12'o0011, 1'b0);
    feed_word(12'o0022); cpu_break(15'o37777, 1'b1, 12'o0022, 1'b0);
    feed_word(12'o0033); cpu_break(15'o30000, 1'b1, 12'o0033, 1'b0);
    feed_word(12'o0044); cpu_break(15'o30001, 1'b1, 12'o0044, 1'b0);
    check("wrap_done", done, 1'b1);
    check("wrap_cur_addr", cur_addr, 15'o30002);
    cyc();

    // Count 0 moves 4096 words and returns the address to its start.
    start_xfer(1'b1, 15'o52000, 12'd0, 1'b0);
    dout_ready = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      if (timeouts > 0) break;
      w = 12'o2000 + 12'(i);
      cpu_break({3'o5, w}, 1'b0, 12'(i), 1'b0);
      cyc();
      if (i < 4095) check("c0_no_early_done", done, 1'b0);
      else          check("c0_done", done, 1'b1);
    end
    dout_ready = 1'b0;
    check("c0_cur_addr", cur_addr, 15'o52000);
    cyc();

    // Abort during DB1 of word 2 of 5: word 2 completes, nothing further.
    we0 = we_count;
    start_xfer(1'b0, 15'o01000, 12'd5, 1'b0);
    feed_word(12'o0101); cpu_break(15'o01000, 1'b1, 12'o0101, 1'b0);
    feed_word(12'o0202); cpu_break(15'o01001, 1'b1, 12'o0202, 1'b1);
    check("ab_done", done, 1'b1);
    check("ab_cur_addr", cur_addr, 15'o01002);
    check("ab_we_pulses", we_count - we0, 2);
    repeat (4) begin
      cyc();
      check("ab_no_req", data_break, 1'b0);
      check("ab_no_fill", din_ready, 1'b0);
      check("ab_idle", busy, 1'b0);
    end

    // Abort while requesting (before DB0): request falls in the same cycle.
    start_xfer(1'b1, 15'o04000, 12'd3, 1'b0);
    check("abreq_req", data_break, 1'b1);
    abort = 1'b1;
    #1;
    check("abreq_drop", data_break, 1'b0);
    cyc();
    abort = 1'b0;
    check("abreq_done", done, 1'b1);
    check("abreq_cur_addr", cur_addr, 15'o04000);
    cyc();

    // Reset during a request abandons it without a done pulse.
    d0 = done_count;
    start_xfer(1'b1, 15'o00200, 12'd3, 1'b0);
    check("rstx_req", data_break, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("rstx_req_drop", data_break, 1'b0);
    check("rstx_busy", busy, 1'b0);
    check("rstx_cur_addr", cur_addr, 15'o0);
    cyc();
    check("rstx_no_done", done, 1'b0);
    check("rstx_done_count", done_count - d0, 0);

    // Fresh start after reset, issued together with abort: abort is ignored.
    we0 = we_count;
    start_xfer(1'b0, 15'o00300, 12'd2, 1'b1);
    check("sa_busy", busy, 1'b1);
    feed_word(12'o6001); cpu_break(15'o00300, 1'b1, 12'o6001, 1'b0);
    check("sa_no_early_done", done, 1'b0);
    feed_word(12'o6002); cpu_break(15'o00301, 1'b1, 12'o6002, 1'b0);
    check("sa_done", done, 1'b1);
    check("sa_cur_addr", cur_addr, 15'o00302);
    check("sa_we_pulses", we_count - we0, 2);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
